// File: rtl/systemverilog_bus_arb.sv
// Round-robin arbiter that accepts one 64-bit {dat, adr} word from one of PORTS
// requesters and serialises it LSB-first as eight bytes onto a ready/valid stream.
module systemverilog_bus_arb #(
  parameter int PORTS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PORTS-1:0]       bus_vld,
  input  logic [PORTS-1:0][31:0] bus_adr,
  input  logic [PORTS-1:0][31:0] bus_dat,
  output logic [PORTS-1:0]       bus_rdy,
  output logic                   str_vld,
  output logic [7:0]             str_bus,
  input  logic                   str_rdy,
  output logic                   str_lst,
  output logic [2:0]             str_src,
  output logic                   busy
);

  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [PW-1:0]   ptr_reg;
  logic [PW-1:0]   ptr_next;
  logic [PW-1:0]   src_reg;
  logic [2:0]      cnt_reg;
  logic [63:0]     pkt_reg;
  logic [7:0]      str_bus_reg;

  logic [PW-1:0]   rr_idx [PORTS];
  logic [PW:0]     rr_sum [PORTS];
  logic [PW-1:0]   win_idx;
  logic            win_found;
  logic [PW:0]     win_inc;
  logic [7:0]      pkt_byte [8];
  logic            bus_xfer;
  logic            str_xfer;
  logic            last_byte;

  // Candidate index for each search offset, already wrapped modulo PORTS.
  for (genvar gi = 0; gi < PORTS; gi++) begin : g_rr
    assign rr_sum[gi] = {1'b0, ptr_reg} + (PW+1)'(gi);
    assign rr_idx[gi] = (rr_sum[gi] >= (PW+1)'(PORTS)) ?
                        PW'(rr_sum[gi] - (PW+1)'(PORTS)) : rr_sum[gi][PW-1:0];
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int off = 0; off < PORTS; off++) begin
      if (!win_found && bus_vld[rr_idx[off]]) begin
        win_found = 1'b1;
        win_idx   = rr_idx[off];
      end
    end
  end

  assign win_inc  = {1'b0, win_idx} + 1'b1;
  assign ptr_next = (win_inc == (PW+1)'(PORTS)) ? '0 : win_inc[PW-1:0];

  for (genvar gi = 0; gi < 8; gi++) begin : g_byte
    assign pkt_byte[gi] = pkt_reg[8*gi +: 8];
  end

  assign last_byte = (cnt_reg == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    bus_xfer   = 1'b0;
    str_xfer   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (win_found && !rst) begin
          bus_xfer   = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (str_rdy) begin
          str_xfer = 1'b1;
          if (last_byte) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < PORTS; gi++) begin : g_rdy
    assign bus_rdy[gi] = bus_xfer && (win_idx == PW'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg     <= '0;
      src_reg     <= '0;
      cnt_reg     <= '0;
      str_bus_reg <= '0;
    end else if (bus_xfer) begin
      ptr_reg     <= ptr_next;
      src_reg     <= win_idx;
      cnt_reg     <= '0;
      str_bus_reg <= bus_adr[win_idx][7:0];
    end else if (str_xfer) begin
      cnt_reg <= cnt_reg + 3'd1;
      // The final byte stays on str_bus through the following IDLE period.
      if (!last_byte) begin
        str_bus_reg <= pkt_byte[cnt_reg + 3'd1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus_xfer) begin
      pkt_reg <= {bus_dat[win_idx], bus_adr[win_idx]};
    end
  end

  assign str_vld = (state_reg == SEND);
  assign busy    = (state_reg == SEND);
  assign str_lst = (state_reg == SEND) && last_byte;
  assign str_bus = str_bus_reg;
  assign str_src = 3'(src_reg);

endmodule

// File: tb/tb_systemverilog_bus_arb.sv
// Bench for systemverilog_bus_arb: a queue-based packet model checked every cycle,
// plus directed scenarios with literal expectations on grants and stream bytes.
module tb_systemverilog_bus_arb;
  localparam int P = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [P-1:0]       bus_vld = '0;
  logic [P-1:0][31:0] bus_adr = '0;
  logic [P-1:0][31:0] bus_dat = '0;
  logic [P-1:0]       bus_rdy;
  logic               str_vld;
  logic [7:0]         str_bus;
  logic               str_rdy = 1'b0;
  logic               str_lst;
  logic [2:0]         str_src;
  logic               busy;

  int checks = 0;
  int errors = 0;

  // Model: pending bytes of the held packet, rotating pointer, last shown values.
  bit          m_busy = 1'b0;
  logic [7:0]  m_q[$];
  int          m_ptr = 0;
  int          m_src = 0;
  logic [7:0]  m_last = 8'h00;

  logic [7:0]  log_bytes[$];
  bit          log_lst[$];
  int          log_grant[$];
  int          activity = 0;

  systemverilog_bus_arb #(.PORTS(P)) dut (
    .clk(clk), .rst(rst),
    .bus_vld(bus_vld), .bus_adr(bus_adr), .bus_dat(bus_dat), .bus_rdy(bus_rdy),
    .str_vld(str_vld), .str_bus(str_bus), .str_rdy(str_rdy), .str_lst(str_lst),
    .str_src(str_src), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic [P-1:0] exp_rdy;
    int w;
    int c;
    if (rst) begin
      m_busy = 1'b0;
      m_q.delete();
      m_ptr  = 0;
      m_src  = 0;
      m_last = 8'h00;
    end
    w = -1;
    if (!rst && !m_busy) begin
      for (int k = 0; k < P; k++) begin
        c = (m_ptr + k) % P;
        if (w < 0 && bus_vld[c]) w = c;
      end
    end
    exp_rdy = (w >= 0) ? (P'(1) << w) : '0;
    chk("bus_rdy", 32'(bus_rdy), 32'(exp_rdy));
    chk("str_vld", 32'(str_vld), 32'(m_busy));
    chk("busy",    32'(busy),    32'(m_busy));
    chk("str_lst", 32'(str_lst), 32'(m_busy && m_q.size() == 1));
    chk("str_bus", 32'(str_bus), 32'(m_last));
    chk("str_src", 32'(str_src), 32'(m_src));

    if (str_vld && str_rdy) begin
      log_bytes.push_back(str_bus);
      log_lst.push_back(str_lst);
    end
    for (int k = 0; k < P; k++) begin
      if (bus_vld[k] && bus_rdy[k]) log_grant.push_back(k);
    end
    if (str_vld || busy || (|bus_rdy)) activity++;

    if (!rst) begin
      if (w >= 0) begin
        for (int b = 0; b < 4; b++) m_q.push_back(bus_adr[w][8*b +: 8]);
        for (int b = 0; b < 4; b++) m_q.push_back(bus_dat[w][8*b +: 8]);
        m_busy = 1'b1;
        m_src  = w;
        m_ptr  = (w + 1) % P;
        m_last = m_q[0];
      end else if (m_busy && str_rdy) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_busy = 1'b0;
        else m_last = m_q[0];
      end
    end
  end

  // Runs n cycles; rdy_mode 1 gives the 1,0,0 backpressure pattern; drop clears
  // a requester's bus_vld once it has been granted.
  task automatic run(input int n, input logic [P-1:0] vld_set, input bit drop, input int rdy_mode);
    logic [P-1:0] g;
    bus_vld = bus_vld | vld_set;
    for (int i = 0; i < n; i++) begin
      str_rdy = (rdy_mode == 1) ? (i % 3 == 0) : 1'b1;
      @(negedge clk);
      g = bus_vld & bus_rdy;
      @(posedge clk);
      #1;
      if (drop) bus_vld = bus_vld & ~g;
    end
    str_rdy = 1'b1;
  endtask

  task automatic clear_logs();
    log_bytes.delete();
    log_lst.delete();
    log_grant.delete();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_seq_bytes(input string name, input logic [7:0] base);
    chk({name, "_count"}, 32'(log_bytes.size()), 32'd8);
    for (int i = 0; i < 8 && i < log_bytes.size(); i++) begin
      chk({name, "_byte"}, 32'(log_bytes[i]), 32'(base + 8'(i)));
      chk({name, "_lst"},  32'(log_lst[i]),   32'(i == 7));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_str_vld", 32'(str_vld), 32'd0);
    chk("reset_busy",    32'(busy),    32'd0);
    chk("reset_bus_rdy", 32'(bus_rdy), 32'd0);
    chk("reset_str_bus", 32'(str_bus), 32'd0);
    rst = 1'b0;

    // Single requester on port 0.
    bus_adr[0] = 32'h03020100;
    bus_dat[0] = 32'h07060504;
    clear_logs();
    run(12, 4'b0001, 1'b1, 0);
    chk("single_grants", 32'(log_grant.size()), 32'd1);
    if (log_grant.size() > 0) chk("single_port", 32'(log_grant[0]), 32'd0);
    chk_seq_bytes("single", 8'h00);

    // All ports continuously: order 0,1,2,3,0 from a fresh reset.
    pulse_reset();
    for (int i = 0; i < P; i++) begin
      bus_adr[i] = 32'h03020100 + 32'(i) * 32'h40404040;
      bus_dat[i] = 32'h07060504 + 32'(i) * 32'h40404040;
    end
    clear_logs();
    run(37, 4'b1111, 1'b0, 0);
    bus_vld = '0;
    run(10, 4'b0000, 1'b0, 0);
    chk("rr_grants", 32'(log_grant.size()), 32'd5);
    for (int i = 0; i < 5 && i < log_grant.size(); i++)
      chk("rr_order", 32'(log_grant[i]), 32'(i % 4));
    chk("rr_bytes", 32'(log_bytes.size()), 32'd40);

    // Backpressure on a port-1 packet.
    bus_adr[1] = 32'h03020100;
    bus_dat[1] = 32'h07060504;
    clear_logs();
    run(30, 4'b0010, 1'b1, 1);
    chk_seq_bytes("bp", 8'h00);

    // Port 2 granted, then ports 1 and 3 compete: 3 wins before 1.
    clear_logs();
    run(3, 4'b0100, 1'b1, 0);
    run(30, 4'b1010, 1'b1, 0);
    chk("ptr_grants", 32'(log_grant.size()), 32'd3);
    if (log_grant.size() == 3) begin
      chk("ptr_first",  32'(log_grant[0]), 32'd2);
      chk("ptr_second", 32'(log_grant[1]), 32'd3);
      chk("ptr_third",  32'(log_grant[2]), 32'd1);
    end

    // Reset after byte 3 of a port-0 packet.
    bus_adr[0] = 32'h03020100;
    bus_dat[0] = 32'h07060504;
    clear_logs();
    run(5, 4'b0001, 1'b1, 0);
    chk("pre_rst_bytes", 32'(log_bytes.size()), 32'd4);
    rst = 1'b1;
    #1;
    chk("rst_str_vld", 32'(str_vld), 32'd0);
    chk("rst_str_bus", 32'(str_bus), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(3, 4'b0000, 1'b0, 0);
    chk("post_rst_bytes", 32'(log_bytes.size()), 32'd4);
    bus_adr[1] = 32'h13121110;
    bus_dat[1] = 32'h17161514;
    clear_logs();
    run(12, 4'b0010, 1'b1, 0);
    chk("after_rst_grants", 32'(log_grant.size()), 32'd1);
    if (log_grant.size() > 0) chk("after_rst_port", 32'(log_grant[0]), 32'd1);
    chk_seq_bytes("after_rst", 8'h10);

    // Idle with sink ready: nothing moves.
    clear_logs();
    activity = 0;
    run(20, 4'b0000, 1'b0, 0);
    chk("idle_activity", 32'(activity), 32'd0);
    chk("idle_bytes", 32'(log_bytes.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systemverilog_bus_arb.md
SYSTEMVERILOG_BUS_ARB -- requirements
Module: systemverilog_bus_arb

Interface
REQ-001 Parameter PORTS, default 4, meaning number of bus requesters sharing the stream (legal 2..8).
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 bus_vld  input  PORTS  per-requester valid (chip select).
REQ-005 bus_adr  input  PORTS x 32  per-requester address.
REQ-006 bus_dat  input  PORTS x 32  per-requester data.
REQ-007 bus_rdy  output  PORTS  per-requester ready (acknowledge); at most one bit set.
REQ-008 str_vld  output  1  stream byte valid.
REQ-009 str_bus  output  8  stream byte.
REQ-010 str_rdy  input  1  stream sink ready.
REQ-011 str_lst  output  1  marks the 8th (final) byte of a packet.
REQ-012 str_src  output  3  index of the requester that owns the current packet.
REQ-013 busy  output  1  high while a packet is held (state SEND).

Function
REQ-014 FSM states: IDLE, SEND; reset state IDLE.
REQ-015 A bus transfer occurs when bus_vld[i] & bus_rdy[i]; a stream transfer occurs when str_vld & str_rdy.
REQ-016 In IDLE, bus_rdy SHALL be combinational: exactly one bit set, for the round-robin winner among asserted bus_vld bits; all zero if no bus_vld.
REQ-017 In SEND, bus_rdy SHALL be all zero.
REQ-018 Round-robin: search starts at index ptr and wraps modulo PORTS; first asserted bus_vld wins.
REQ-019 ptr reset value 0; on a bus transfer from index g, ptr <= (g+1) mod PORTS.
REQ-020 On a bus transfer: pkt <= {bus_dat[g], bus_adr[g]} (64 bits), src <= g, cnt <= 0, state <= SEND.
REQ-021 Byte k of a packet = pkt[8k+7:8k]; bytes 0..3 are adr LSB-first, bytes 4..7 are dat LSB-first.
REQ-022 In SEND: str_vld = 1, str_bus = byte[cnt], str_src = src, str_lst = (cnt == 7).
REQ-023 In IDLE: str_vld = 0, str_lst = 0; str_bus and str_src hold their last value (don't-care to sink).
REQ-024 On a stream transfer with cnt < 7: cnt <= cnt + 1 (3-bit).
REQ-025 On a stream transfer with cnt == 7: state <= IDLE; cnt wraps to 0.
REQ-026 When str_rdy = 0 in SEND: cnt, pkt, src, str_bus SHALL hold (byte not lost or repeated).
REQ-027 Latency: bus transfer in cycle N -> byte 0 presented with str_vld in cycle N+1; minimum packet period 9 cycles (8 bytes + 1 IDLE cycle).
REQ-028 Simultaneous bus_vld from several ports in IDLE: only the winner gets bus_rdy; losers keep bus_vld asserted and are served in later packets.
REQ-029 A requester deasserting bus_vld before being granted is simply skipped; no state change.
REQ-030 str_rdy asserted while str_vld = 0 SHALL have no effect.
REQ-031 Counter widths: cnt 3 bits, ptr and src $clog2(PORTS) bits, zero-extended onto str_src.

Reset
REQ-032 On rst assertion (any cycle, including mid-packet): state = IDLE, cnt = 0, ptr = 0, src = 0, str_vld = 0, str_lst = 0, bus_rdy = 0, busy = 0, str_bus = 0; held packet discarded.
REQ-033 pkt contents need not be reset.
REQ-034 First grant after reset release SHALL start search at port 0.

Verification
REQ-035 Single port: bus_vld[0]=1, adr=0x03020100, dat=0x07060504, str_rdy=1 -> bus_rdy[0] one cycle, then str_bus 0x00..0x07 on 8 consecutive cycles, str_lst on 0x07, str_src=0.
REQ-036 All 4 ports request continuously -> grants in order 0,1,2,3,0; each packet 8 bytes, 1 idle cycle between packets.
REQ-037 Backpressure: str_rdy toggled 1,0,0,1,... -> each byte held while str_rdy=0, sequence 0x00..0x07 intact, no duplicates.
REQ-038 Port 2 granted, then ports 1 and 3 request -> next grant port 3 (ptr=3), then port 1.
REQ-039 rst pulsed after byte 3 -> str_vld=0 immediately, no further bytes; next request from port 1 alone is granted and sent from byte 0.
REQ-040 No requests, str_rdy=1 for 20 cycles -> str_vld, bus_rdy, busy stay 0.
